traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Four-approach intersection signal scheduler that generalises the two-road car-sensor controller to four phases.
- Grants green to one approach at a time, round-robin among approaches with waiting cars.
- Enforces minimum/maximum green, yellow and all-red clearance intervals, and supports emergency preemption.
- Drives per-approach light outputs directly at the signal-head level of the lab design.

Parameters:
- MIN_GREEN, 4, minimum green cycles before a phase may yield to a competing request (≥1)
- MAX_GREEN, 12, green cycles after which a phase must yield if others wait (≥ MIN_GREEN)
- YELLOW_T, 2, yellow cycles (≥1)
- ALLRED_T, 1, all-red clearance cycles (≥1)
- CNT_W, 6, timer width; must hold max(MAX_GREEN, YELLOW_T, ALLRED_T)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  car-present sensor per approach, bit k = approach k; level, sampled every cycle
- pre_req  in  1  emergency preemption request, level
- pre_phase  in  2  approach to be served under preemption
- light  out  12  {light3,light2,light1,light0}, 3 bits each: green=3'b001, yellow=3'b010, red=3'b100
- cur_phase  out  2  approach currently owning green/yellow (the last served approach during all-red)
- in_clear  out  1  high during YELLOW and ALLRED

Behaviour:
- FSM states: GREEN, YELLOW, ALLRED. Registers: state, cur_phase, next_phase, timer (CNT_W bits).
- Outputs are decoded only from registered state; there is no combinational path from inputs to outputs.
  - GREEN: light[cur_phase] = green.
  - YELLOW: light[cur_phase] = yellow.
  - ALLRED: all approaches red.
  - All non-owning approaches are always red.
- Reset (rst=1 at a clock edge, in any state including mid-yellow or mid-all-red):
  - state=GREEN, cur_phase=0, next_phase=0, timer=0.
  - light=12'h921, in_clear=0.
- Timer:
  - Cleared to 0 on every state entry; increments once per cycle.
  - In GREEN it saturates at MAX_GREEN-1.
- Definition: other = req with bit cur_phase masked.
- GREEN exit: evaluated each cycle; go to YELLOW on the next edge when any of the following holds.
  - (a) pre_req=1 and pre_phase≠cur_phase; this ignores MIN_GREEN.
  - (b) pre_req=0, other≠0, timer ≥ MIN_GREEN-1 and req[cur_phase]=0.
  - (c) pre_req=0, other≠0 and timer ≥ MAX_GREEN-1.
- GREEN hold cases:
  - pre_req=1 with pre_phase=cur_phase holds GREEN indefinitely, ignoring MAX_GREEN.
  - other=0 holds GREEN indefinitely.
- next_phase latch on GREEN exit:
  - Preemption case: next_phase = pre_phase.
  - Otherwise: next_phase = first k with other[k]=1, searching cur_phase+1, +2, +3 modulo 4 (round-robin wrap-around).
- YELLOW: lasts exactly YELLOW_T cycles, then ALLRED.
- ALLRED: lasts exactly ALLRED_T cycles, then GREEN with cur_phase ← next_phase and timer=0.
- Preemption during YELLOW/ALLRED:
  - If pre_req=1, next_phase is overwritten with pre_phase every cycle.
  - Clearance durations are never shortened.
- Green duration from first green cycle:
  - Without preemption: at least MIN_GREEN cycles.
  - When others wait: at most MAX_GREEN cycles.
- Phase sequence per handover: GREEN → YELLOW_T cycles → ALLRED_T cycles → new GREEN. Two approaches are never simultaneously non-red.
- in_clear = 1 exactly in YELLOW and ALLRED.

Test Plan (defaults; cycle 0 = first edge after rst deasserts):
- Reset: hold rst=1 for 2 cycles, any req → light=12'h921, cur_phase=0, in_clear=0; repeat with rst asserted mid-YELLOW → 12'h921 on the next cycle, timer restarts at 0.
- Minimum green: req=4'b0010 from reset:
  - Phase 0 green for cycles 0–3.
  - Yellow (light0=010) for cycles 4–5.
  - All-red (12'h924) for cycle 6.
  - light=12'h90C with cur_phase=1 from cycle 7.
- Maximum green: req=4'b0011 held → phase 0 green for 12 cycles (0–11), yellow at cycles 12–13, then phase 1 green at cycle 15.
- Round-robin wrap: cur_phase=1 at green exit with req=4'b1001 → next green is phase 3; later, with phase 3 green and req=4'b1011, the next green is phase 0.
- Preemption:
  - During phase 0 green at timer=1, assert pre_req=1, pre_phase=2 → yellow on the next cycle, then all-red, then phase 2 green.
  - Holding pre_req while phase 2 is green with req=4'b1111 → phase 2 stays green beyond 12 cycles.
- Preemption retarget: latched next_phase=1; during ALLRED assert pre_req=1, pre_phase=3 → phase 3 gets green, and ALLRED still lasts 1 cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Four-approach signal scheduler: round-robin green among waiting approaches with
// min/max green, yellow and all-red clearance, plus emergency preemption.
module traffic_phase_scheduler #(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 12,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned CNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        pre_req,
    input  logic [1:0]  pre_phase,
    output logic [11:0] light,
    output logic [1:0]  cur_phase,
    output logic        in_clear
);

    typedef enum logic [1:0] {
        StGreen,
        StYellow,
        StAllRed
    } state_e;

    localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MaxLast = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YelLast = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ArLast  = CNT_W'(ALLRED_T - 1);

    state_e           state_q, state_d;
    logic [1:0]       cur_phase_q, cur_phase_d;
    logic [1:0]       next_phase_q, next_phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic [3:0] other;
    logic [1:0] rr_phase;
    logic       min_done;
    logic       max_done;
    logic       green_exit;

    always_comb begin
        other    = req & ~(4'b0001 << cur_phase_q);
        min_done = timer_q >= MinLast;
        max_done = timer_q >= MaxLast;
        green_exit = (pre_req && (pre_phase != cur_phase_q)) ||
                     (!pre_req && (other != 4'b0000) &&
                      ((min_done && !req[cur_phase_q]) || max_done));
    end

    // Walk offsets 3..1 so the nearest waiting approach after cur_phase wins.
    always_comb begin
        rr_phase = cur_phase_q;
        for (int i = 3; i >= 1; i--) begin
            if (other[cur_phase_q + 2'(i)]) begin
                rr_phase = cur_phase_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_phase_d  = cur_phase_q;
        next_phase_d = next_phase_q;
        timer_d      = timer_q;
        unique case (state_q)
            StGreen: begin
                if (green_exit) begin
                    state_d      = StYellow;
                    timer_d      = '0;
                    next_phase_d = pre_req ? pre_phase : rr_phase;
                end else if (!max_done) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StYellow: begin
                if (pre_req) begin
                    next_phase_d = pre_phase;
                end
                if (timer_q >= YelLast) begin
                    state_d = StAllRed;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAllRed: begin
                if (pre_req) begin
                    next_phase_d = pre_phase;
                end
                if (timer_q >= ArLast) begin
                    state_d     = StGreen;
                    timer_d     = '0;
                    // A preemption arriving in the last all-red cycle still retargets.
                    cur_phase_d = next_phase_d;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StGreen;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StGreen;
            cur_phase_q  <= 2'd0;
            next_phase_q <= 2'd0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_phase_q  <= cur_phase_d;
            next_phase_q <= next_phase_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        light = {4{3'b100}};
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == cur_phase_q) begin
                if (state_q == StGreen) begin
                    light[3*k +: 3] = 3'b001;
                end else if (state_q == StYellow) begin
                    light[3*k +: 3] = 3'b010;
                end
            end
        end
    end

    assign cur_phase = cur_phase_q;
    assign in_clear  = (state_q != StGreen);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: a per-cycle check against a
// green-length / clearance-countdown model plus literal waveform checkpoints.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic        pre_req = 1'b0;
    logic [1:0]  pre_phase = 2'd0;
    logic [11:0] light;
    logic [1:0]  cur_phase;
    logic        in_clear;
    logic        chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    traffic_phase_scheduler #(
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .CNT_W    (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .pre_req  (pre_req),
        .pre_phase(pre_phase),
        .light    (light),
        .cur_phase(cur_phase),
        .in_clear (in_clear)
    );

    always #5 clk = ~clk;

    // Model: owner approach, cycles of green shown so far, remaining clearance cycles
    // (YELLOW_T+ALLRED_T counting down; 0 means green), and the pending target.
    int m_owner  = 0;
    int m_glen   = 1;
    int m_clear  = 0;
    int m_target = 0;

    always @(posedge clk) begin
        int         o, g, c, t;
        logic [3:0] others;
        bit         found;
        o = m_owner; g = m_glen; c = m_clear; t = m_target;
        if (rst) begin
            o = 0; g = 1; c = 0; t = 0;
        end else if (c == 0) begin
            others = req;
            others[o] = 1'b0;
            if (pre_req && (int'(pre_phase) != o)) begin
                c = YELLOW_T + ALLRED_T;
                t = int'(pre_phase);
            end else if (!pre_req && (others != 0) &&
                         ((g >= MIN_GREEN && !req[o]) || g >= MAX_GREEN)) begin
                c = YELLOW_T + ALLRED_T;
                found = 1'b0;
                for (int d = 1; d <= 3; d++) begin
                    if (!found && others[(o + d) % 4]) begin
                        t = (o + d) % 4;
                        found = 1'b1;
                    end
                end
            end else begin
                g = g + 1;
            end
        end else begin
            if (pre_req) t = int'(pre_phase);
            if (c == 1) begin
                o = t; g = 1; c = 0;
            end else begin
                c = c - 1;
            end
        end
        m_owner  <= o;
        m_glen   <= g;
        m_clear  <= c;
        m_target <= t;
    end

    function automatic logic [11:0] exp_light(int owner, int clear);
        logic [11:0] l;
        l = {4{3'b100}};
        if (clear == 0) l[3*owner +: 3] = 3'b001;
        else if (clear > ALLRED_T) l[3*owner +: 3] = 3'b010;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_light", 32'(light), 32'(exp_light(m_owner, m_clear)));
            check("model_cur_phase", 32'(cur_phase), 32'(m_owner));
            check("model_in_clear", 32'(in_clear), 32'(m_clear != 0));
        end
    end

    // Leaves the bench at the negedge that samples cycle 0.
    task automatic do_reset(input logic [3:0] r);
        @(negedge clk);
        rst = 1'b1; req = r; pre_req = 1'b0; pre_phase = 2'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Minimum green handover 0 -> 1
        do_reset(4'b0010);
        check("rst_light", 32'(light), 32'h921);
        check("rst_cur_phase", 32'(cur_phase), 32'd0);
        check("rst_in_clear", 32'(in_clear), 32'd0);
        wait_cyc(3);
        check("min_green_c3", 32'(light), 32'h921);
        wait_cyc(1);
        check("min_yellow_c4", 32'(light), 32'h922);
        check("min_clear_c4", 32'(in_clear), 32'd1);
        wait_cyc(2);
        check("min_allred_c6", 32'(light), 32'h924);
        wait_cyc(1);
        check("min_next_c7", 32'(light), 32'h90C);
        check("min_next_phase", 32'(cur_phase), 32'd1);

        // Reset mid-yellow, then the green timer restarts from 0
        do_reset(4'b0010);
        wait_cyc(4);
        check("mid_yellow", 32'(light), 32'h922);
        rst = 1'b1;
        wait_cyc(1);
        check("mid_rst_light", 32'(light), 32'h921);
        check("mid_rst_clear", 32'(in_clear), 32'd0);
        rst = 1'b0;
        wait_cyc(3);
        check("restart_green_c3", 32'(light), 32'h921);
        wait_cyc(1);
        check("restart_yellow_c4", 32'(light), 32'h922);

        // Maximum green with phase 0 still requesting
        do_reset(4'b0011);
        wait_cyc(11);
        check("max_green_c11", 32'(light), 32'h921);
        wait_cyc(1);
        check("max_yellow_c12", 32'(light), 32'h922);
        wait_cyc(3);
        check("max_next_c15", 32'(light), 32'h90C);

        // Round-robin wrap: 1 -> 3 -> 0
        req = 4'b1001;
        wait_cyc(7);
        check("rr_phase3_light", 32'(light), 32'h324);
        check("rr_phase3", 32'(cur_phase), 32'd3);
        req = 4'b1011;
        wait_cyc(14);
        check("rr_allred_c36", 32'(light), 32'h924);
        wait_cyc(1);
        check("rr_wrap_phase0", 32'(cur_phase), 32'd0);
        check("rr_wrap_light", 32'(light), 32'h921);

        // Preemption from phase 0 at timer=1, held past max green
        do_reset(4'b0000);
        wait_cyc(1);
        pre_req = 1'b1; pre_phase = 2'd2;
        wait_cyc(1);
        check("pre_yellow", 32'(light), 32'h922);
        wait_cyc(2);
        check("pre_allred", 32'(light), 32'h924);
        wait_cyc(1);
        check("pre_green2", 32'(light), 32'h864);
        req = 4'b1111;
        wait_cyc(20);
        check("pre_hold", 32'(light), 32'h864);
        pre_req = 1'b0;
        wait_cyc(6);

        // Retarget during all-red: latched 1, preempt to 3
        do_reset(4'b0010);
        wait_cyc(6);
        check("retarget_allred", 32'(light), 32'h924);
        pre_req = 1'b1; pre_phase = 2'd3;
        wait_cyc(1);
        check("retarget_green3", 32'(light), 32'h324);
        check("retarget_phase", 32'(cur_phase), 32'd3);
        pre_req = 1'b0; req = 4'b0000;
        wait_cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
